// File: rtl/debug_uart_rx_if.sv
// Bus-side view of the debug UART receiver: FIFO head, status flags, pop/clear strobes.
`timescale 1ns/1ps
interface debug_uart_rx_if #(
  parameter int unsigned FIFO_DEPTH = 4
);
  localparam int unsigned OCC_W = $clog2(FIFO_DEPTH) + 1;

  logic             rx_pop;
  logic             err_clear;
  logic [7:0]       rx_data;
  logic             rx_valid;
  logic [OCC_W-1:0] rx_count;
  logic             rx_busy;
  logic             overrun;
  logic             frame_err;
  logic             irq;

  modport slave (
    input  rx_pop, err_clear,
    output rx_data, rx_valid, rx_count, rx_busy, overrun, frame_err, irq
  );

  modport master (
    output rx_pop, err_clear,
    input  rx_data, rx_valid, rx_count, rx_busy, overrun, frame_err, irq
  );
endinterface

// File: rtl/debug_uart_rx.sv
// Debug UART receiver, 8N1 LSB first, with a small receive FIFO and sticky error flags.
`timescale 1ns/1ps
module debug_uart_rx #(
  parameter int unsigned CLK_HZ     = 14_000_000,
  parameter int unsigned BIT_RATE   = 1_000_000,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           uart_rxd,
  debug_uart_rx_if.slave bus
);

  localparam int unsigned CPB   = CLK_HZ / BIT_RATE;
  localparam int unsigned HALF  = CPB / 2;
  localparam int unsigned CNT_W = $clog2(CPB);
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned OCC_W = PTR_W + 1;

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  state_t           r_state, w_state_n;
  logic             r_sync1, r_rxd_s;
  logic [CNT_W-1:0] r_bit_cnt, w_bit_cnt_n;
  logic [2:0]       r_idx, w_idx_n;
  logic [7:0]       r_shreg, w_shreg_n;
  logic             w_tick, w_push, w_ferr_set;

  logic [7:0]       r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] r_wr_ptr, r_rd_ptr;
  logic [OCC_W-1:0] r_count;
  logic             r_overrun, r_frame_err;
  logic             w_empty, w_full, w_pop, w_write, w_ovr_set;

  // Two-flop synchroniser; idles high so reset never looks like a start bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= 1'b1;
      r_rxd_s <= 1'b1;
    end else begin
      r_sync1 <= uart_rxd;
      r_rxd_s <= r_sync1;
    end
  end

  assign w_tick = (r_bit_cnt == '0);

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_n;
  end

  // Next-state, bit timing and shift logic.
  always_comb begin
    w_state_n   = r_state;
    w_bit_cnt_n = w_tick ? r_bit_cnt : r_bit_cnt - CNT_W'(1);
    w_idx_n     = r_idx;
    w_shreg_n   = r_shreg;
    w_push      = 1'b0;
    w_ferr_set  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!r_rxd_s) begin
          w_state_n   = S_START;
          w_bit_cnt_n = CNT_W'(HALF - 1);
        end
      end
      S_START: begin
        if (w_tick) begin
          if (r_rxd_s) begin
            w_state_n = S_IDLE;
          end else begin
            w_state_n   = S_DATA;
            w_bit_cnt_n = CNT_W'(CPB - 1);
            w_idx_n     = 3'd0;
          end
        end
      end
      S_DATA: begin
        if (w_tick) begin
          w_shreg_n   = {r_rxd_s, r_shreg[7:1]};
          w_idx_n     = r_idx + 3'd1;
          w_bit_cnt_n = CNT_W'(CPB - 1);
          if (r_idx == 3'd7) w_state_n = S_STOP;
        end
      end
      S_STOP: begin
        if (w_tick) begin
          w_state_n = S_IDLE;
          if (r_rxd_s) w_push     = 1'b1;
          else         w_ferr_set = 1'b1;
        end
      end
      default: w_state_n = S_IDLE;
    endcase
  end

  // Bit timing and shift registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_bit_cnt <= '0;
      r_idx     <= '0;
      r_shreg   <= '0;
    end else begin
      r_bit_cnt <= w_bit_cnt_n;
      r_idx     <= w_idx_n;
      r_shreg   <= w_shreg_n;
    end
  end

  // A pop on an empty FIFO is ignored; a push while full only lands if a pop frees a slot.
  assign w_empty   = (r_count == '0);
  assign w_full    = (r_count == OCC_W'(FIFO_DEPTH));
  assign w_pop     = bus.rx_pop & ~w_empty;
  assign w_write   = w_push & (~w_full | w_pop);
  assign w_ovr_set = w_push & w_full & ~w_pop;

  // FIFO storage; contents are don't-care while unoccupied so no reset is needed.
  always_ff @(posedge clk) begin
    if (w_write) r_mem[r_wr_ptr] <= r_shreg;
  end

  // FIFO pointers and occupancy; pointers wrap naturally at the power-of-2 depth.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_write) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)   r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_write, w_pop})
        2'b10:   r_count <= r_count + OCC_W'(1);
        2'b01:   r_count <= r_count - OCC_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Sticky error flags; a set event beats a simultaneous clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_overrun   <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      if (w_ovr_set)          r_overrun <= 1'b1;
      else if (bus.err_clear) r_overrun <= 1'b0;
      if (w_ferr_set)         r_frame_err <= 1'b1;
      else if (bus.err_clear) r_frame_err <= 1'b0;
    end
  end

  assign bus.rx_data   = w_empty ? 8'h00 : r_mem[r_rd_ptr];
  assign bus.rx_valid  = ~w_empty;
  assign bus.rx_count  = r_count;
  assign bus.rx_busy   = (r_state != S_IDLE);
  assign bus.overrun   = r_overrun;
  assign bus.frame_err = r_frame_err;
  assign bus.irq       = ~w_empty | r_overrun | r_frame_err;

endmodule
